// File: rtl/branch_predictor_controller_if.sv
// Lookup, resolve and predictor-table signals shared by the controller and its environment.
// master = fetch/execute/table side, slave = branch_predictor_controller.
interface branch_predictor_controller_if #(
  parameter int unsigned IDX_W = 7
);
  logic             lk_valid;
  logic             lk_ready;
  logic [31:0]      lk_pc;
  logic             pred_valid;
  logic             pred_taken;
  logic             rs_valid;
  logic             rs_ready;
  logic [31:0]      rs_pc;
  logic             rs_taken;
  logic             tbl_en;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_wdata;
  logic [1:0]       tbl_rdata;
  logic             init_done;

  modport master (
    output lk_valid, lk_pc, rs_valid, rs_pc, rs_taken, tbl_rdata,
    input  lk_ready, pred_valid, pred_taken, rs_ready,
    input  tbl_en, tbl_we, tbl_addr, tbl_wdata, init_done
  );

  modport slave (
    input  lk_valid, lk_pc, rs_valid, rs_pc, rs_taken, tbl_rdata,
    output lk_ready, pred_valid, pred_taken, rs_ready,
    output tbl_en, tbl_we, tbl_addr, tbl_wdata, init_done
  );
endinterface

// File: rtl/branch_predictor_controller.sv
// Two-bit saturating-counter branch predictor controller driving an external single-port table.
// Resolves are queued in a small FIFO and applied as read-modify-write when the table is free.
module branch_predictor_controller #(
  parameter int unsigned IDX_W      = 7,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  INIT_VAL   = 2'b10
) (
  input logic                          clk,
  input logic                          reset,
  branch_predictor_controller_if.slave bus
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LK_WAIT,
    UPD_RD,
    UPD_WR
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] init_cnt_q;
  logic             init_done_q;
  logic             pred_valid_q;
  logic             pred_taken_q;
  logic [IDX_W-1:0] upd_idx_q;
  logic             upd_taken_q;

  logic [IDX_W:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] rs_idx;
  logic             is_idle;
  logic             lk_ready;
  logic             rs_ready;
  logic             push;
  logic             start_lk;
  logic             start_upd;
  logic [1:0]       ctr_next;

  logic             tbl_en;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_wdata;

  logic             unused_pc_bits;

  assign lk_idx = bus.lk_pc[IDX_W+1:2];
  assign rs_idx = bus.rs_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.lk_pc[31:IDX_W+2], bus.lk_pc[1:0],
                            bus.rs_pc[31:IDX_W+2], bus.rs_pc[1:0]};

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign is_idle    = (state_q == IDLE);

  assign lk_ready  = is_idle && init_done_q && !fifo_full;
  assign rs_ready  = init_done_q && !fifo_full;
  assign push      = bus.rs_valid && rs_ready;
  // A full queue pre-empts lookups so resolves can never stall forever.
  assign start_lk  = bus.lk_valid && lk_ready;
  assign start_upd = is_idle && (fifo_full || (!bus.lk_valid && !fifo_empty));

  always_comb begin
    ctr_next = bus.tbl_rdata;
    if (upd_taken_q) begin
      if (bus.tbl_rdata != 2'b11) ctr_next = bus.tbl_rdata + 2'd1;
    end else begin
      if (bus.tbl_rdata != 2'b00) ctr_next = bus.tbl_rdata - 2'd1;
    end
  end

  // Table command is combinational so a lookup read issues in its accept cycle.
  always_comb begin
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_wdata = '0;
    if (!reset) begin
      case (state_q)
        INIT: begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = init_cnt_q;
          tbl_wdata = INIT_VAL;
        end
        IDLE: begin
          if (start_lk) begin
            tbl_en   = 1'b1;
            tbl_addr = lk_idx;
          end
        end
        UPD_RD: begin
          tbl_en   = 1'b1;
          tbl_addr = upd_idx_q;
        end
        UPD_WR: begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = upd_idx_q;
          tbl_wdata = ctr_next;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (start_upd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, start_upd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {rs_idx, bus.rs_taken};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      init_done_q  <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      upd_idx_q    <= '0;
      upd_taken_q  <= 1'b0;
    end else begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + IDX_W'(1);
          if (init_cnt_q == {IDX_W{1'b1}}) begin
            state_q     <= IDLE;
            init_done_q <= 1'b1;
          end
        end
        IDLE: begin
          if (start_upd) begin
            {upd_idx_q, upd_taken_q} <= fifo_mem[rd_ptr_q];
            state_q <= UPD_RD;
          end else if (start_lk) begin
            state_q <= LK_WAIT;
          end
        end
        LK_WAIT: begin
          pred_valid_q <= 1'b1;
          pred_taken_q <= bus.tbl_rdata[1];
          state_q      <= IDLE;
        end
        UPD_RD:  state_q <= UPD_WR;
        UPD_WR:  state_q <= IDLE;
        default: state_q <= INIT;
      endcase
    end
  end

  assign bus.lk_ready   = lk_ready;
  assign bus.rs_ready   = rs_ready;
  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_taken = pred_taken_q;
  assign bus.init_done  = init_done_q;
  assign bus.tbl_en     = tbl_en;
  assign bus.tbl_we     = tbl_we;
  assign bus.tbl_addr   = tbl_addr;
  assign bus.tbl_wdata  = tbl_wdata;

endmodule
